wb_ram_slave: RTL and testbench
===============================

// Module: wb_ram_slave
// PURPOSE
//  Wishbone classic responder backing a word-addressed RAM; the memory end that the LSU/cache
//  master talks to. Decodes a BASE_ADDR window, applies byte-select writes, returns read data
//  with a programmable number of wait states so cache refill/write-back timing is exercised.
// PARAMETERS
//  BASE_ADDR    32'h0000_0000  byte address of word 0; must be 4-byte aligned
//  N_WORDS      1024           RAM depth in 32-bit words; power of 2, >= 2
//  WAIT_CYCLES  1              extra cycles between request capture and ack; 0..255
// PORTS
//  clk        in   1   clock, rising edge
//  rstn_i     in   1   reset, asynchronous, active-low
//  wb_cyc_i   in   1   bus cycle valid
//  wb_stb_i   in   1   strobe; request present when wb_cyc_i & wb_stb_i
//  wb_we_i    in   1   1 = write, 0 = read
//  wb_sel_i   in   4   byte lane enables, bit n -> data[8n+7:8n]
//  wb_adr_i   in   32  byte address; bits [1:0] ignored
//  wb_dat_i   in   32  write data
//  wb_dat_o   out  32  read data, valid while wb_ack_o=1
//  wb_ack_o   out  1   one-cycle transfer acknowledge
//  wb_err_o   out  1   one-cycle error terminate (0 without WB_RAM_ERR_EN)
// BEHAVIOUR
//  - Reset (async): FSM=IDLE, wait counter=0, wb_ack_o=0, wb_err_o=0, wb_dat_o=32'h0.
//    RAM contents not reset. Reset during WAIT aborts transfer, no RAM write performed.
//  - FSM: IDLE -> (cyc&stb) -> WAIT -> ACK -> IDLE.
//    IDLE: on cyc&stb, latch we/sel/adr/dat, cnt<=0; go WAIT (or straight to ACK if WAIT_CYCLES=0).
//    WAIT: cnt++ each cycle; when cnt==WAIT_CYCLES-1 go ACK. cyc low in WAIT -> IDLE, no write.
//    ACK: wb_ack_o (or wb_err_o) high exactly this one cycle; unconditionally -> IDLE.
//  - Latency: ack high in cycle N+1+WAIT_CYCLES for request sampled in IDLE at cycle N.
//    Back-to-back: request held high after ack is re-sampled in IDLE; min period WAIT_CYCLES+2.
//  - cyc&stb in ACK cycle is not a new request; ack never asserted without a latched request.
//  - Commit: on the edge entering ACK, write applies only lanes with sel=1 (sel=0 -> no
//    change, still acked); read loads wb_dat_o with full word (sel ignored on reads).
//  - wb_dat_o holds last read value outside ack; writes do not alter wb_dat_o.
//  - Index = (adr - BASE_ADDR) >> 2, 32-bit unsigned arithmetic. In range iff adr >= BASE_ADDR
//    and index < N_WORDS. Latched inputs used; live bus changes after capture are ignored.
// CONFIGURATION
//  WB_RAM_ERR_EN defined: out-of-range access -> wb_err_o in ACK slot instead of wb_ack_o,
//    no RAM write, wb_dat_o <= 32'h0. Same latency as a normal access.
//  WB_RAM_ERR_EN undefined: wb_err_o tied 0; index wraps modulo N_WORDS
//    (index[$clog2(N_WORDS)-1:0]); access completes with normal ack.
// TESTING (defaults unless noted)
//  1 write 0x0000_0010 dat 0xDEAD_BEEF sel 4'hF, then read 0x10 -> ack 2 cycles after each
//    request sample, read wb_dat_o=0xDEAD_BEEF.
//  2 after 1, write 0x10 dat 0x1122_3344 sel 4'b0101, read -> 0xDE22_BE44; sel 4'h0 write
//    -> ack, data unchanged.
//  3 WAIT_CYCLES=0, 8 back-to-back reads of 0x00..0x1C with stb held -> one ack every 2 cycles,
//    data in address order, no duplicate/missing ack.
//  4 BASE_ADDR=32'h1000, N_WORDS=16: read 0x1040 -> ERR_EN: wb_err_o=1, dat 0, RAM untouched;
//    no ERR_EN: ack, returns word at 0x1000.
//  5 WAIT_CYCLES=4, write started then cyc dropped in WAIT cycle 2 -> no ack, later read shows
//    old value; rstn_i pulse mid-WAIT -> ack/err/dat_o = 0 immediately, no write.

Source files
------------

// File: rtl/wb_ram_slave.sv
// wb_ram_slave: Wishbone classic responder in front of a word-addressed RAM.
// Decodes a BASE_ADDR window, applies byte-select writes, and returns read data
// after WAIT_CYCLES programmable wait states.
// Optional feature macro: WB_RAM_ERR_EN
//   defined   -> out-of-window accesses terminate with wb_err_o, no RAM write
//   undefined -> wb_err_o tied low, word index wraps modulo N_WORDS
module wb_ram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned N_WORDS     = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rstn_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o
);

  localparam int unsigned AW = $clog2(N_WORDS);
  localparam logic [7:0] LAST_CNT = 8'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        capture;
  logic        commit;

  logic        we_q;
  logic [3:0]  sel_q;
  logic [31:0] adr_q;
  logic [31:0] dat_q;
  logic        err_q;

  logic        req_we;
  logic [3:0]  req_sel;
  logic [31:0] req_adr;
  logic [31:0] req_dat;
  logic [31:0] offset;
  logic [AW-1:0] ram_idx;
  logic        acc_err;
  logic        unused_bits;

  logic [31:0] mem [N_WORDS];

  // With WAIT_CYCLES=0 the commit edge is also the capture edge, so the
  // access fields come straight from the bus in IDLE and from the latches later.
  always_comb begin
    if (state_q == S_IDLE) begin
      req_we  = wb_we_i;
      req_sel = wb_sel_i;
      req_adr = wb_adr_i;
      req_dat = wb_dat_i;
    end else begin
      req_we  = we_q;
      req_sel = sel_q;
      req_adr = adr_q;
      req_dat = dat_q;
    end
  end

  // Address decode: 32-bit unsigned offset from the window base, word granular
  always_comb begin
    offset  = req_adr - BASE_ADDR;
    ram_idx = offset[AW+1:2];
`ifdef WB_RAM_ERR_EN
    acc_err = (req_adr < BASE_ADDR) || ({2'b00, offset[31:2]} >= N_WORDS);
`else
    acc_err = 1'b0;
`endif
  end

  assign unused_bits = ^{offset[1:0], offset[31:AW+2]};

  // Next-state logic: IDLE -> WAIT -> ACK -> IDLE, cyc drop in WAIT aborts
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          capture = 1'b1;
          cnt_d   = '0;
          state_d = (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!wb_cyc_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == LAST_CNT) begin
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign commit = (state_d == S_ACK);

  // FSM state, request latches, termination flavour and read data register
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      adr_q    <= '0;
      dat_q    <= '0;
      err_q    <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        we_q  <= wb_we_i;
        sel_q <= wb_sel_i;
        adr_q <= wb_adr_i;
        dat_q <= wb_dat_i;
      end
      if (commit) begin
        err_q <= acc_err;
        if (acc_err) begin
          wb_dat_o <= '0;
        end else if (!req_we) begin
          wb_dat_o <= mem[ram_idx];
        end
      end
    end
  end

  // RAM byte-lane writes on the edge entering ACK; held off while in reset
  always_ff @(posedge clk) begin
    if (rstn_i && commit && req_we && !acc_err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (req_sel[b]) begin
          mem[ram_idx][8*b +: 8] <= req_dat[8*b +: 8];
        end
      end
    end
  end

  assign wb_ack_o = (state_q == S_ACK) && !err_q;
`ifdef WB_RAM_ERR_EN
  assign wb_err_o = (state_q == S_ACK) && err_q;
`else
  assign wb_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_ram_slave.sv
// Testbench for wb_ram_slave: table-driven directed vectors, hand-written
// back-to-back / abort / reset sequences, and randomized traffic checked
// against a word-array reference model.
module tb_wb_ram_slave;

  parameter logic [31:0] BASE = 32'h0000_0000;
  parameter int unsigned NW   = 1024;
  parameter int unsigned WC   = 1;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr, wb_dat;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] mdl [NW];
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  wb_ram_slave #(
    .BASE_ADDR  (BASE),
    .N_WORDS    (NW),
    .WAIT_CYCLES(WC)
  ) dut (
    .clk     (clk),
    .rstn_i  (rstn_i),
    .wb_cyc_i(wb_cyc),
    .wb_stb_i(wb_stb),
    .wb_we_i (wb_we),
    .wb_sel_i(wb_sel),
    .wb_adr_i(wb_adr),
    .wb_dat_i(wb_dat),
    .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o),
    .wb_err_o(wb_err_o)
  );

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        exp_err;
    logic [31:0] exp_dat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: index from spec arithmetic, out-of-window handled per build
  function automatic void model_ref(input logic we, input logic [3:0] sel,
                                    input logic [31:0] adr, input logic [31:0] dat,
                                    output logic e, output logic [31:0] d);
    logic [31:0] off;
    int unsigned widx;
    bit oob;
    off  = adr - BASE;
    widx = off / 4;
    oob  = (adr < BASE) || (widx >= NW);
    widx = widx % NW;
    e = 1'b0;
`ifdef WB_RAM_ERR_EN
    if (oob) begin
      e = 1'b1;
      last_rd = 32'h0;
      d = 32'h0;
      return;
    end
`else
    if (oob) e = 1'b0;
`endif
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (sel[b]) mdl[widx][8*b +: 8] = dat[8*b +: 8];
    end else begin
      last_rd = mdl[widx];
    end
    d = last_rd;
  endfunction

  // One bus transfer, starting and ending at a falling edge. Live bus fields
  // are scrambled after capture to show the latched request is used.
  task automatic xfer(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                      input logic [31:0] dat, output logic [31:0] rd,
                      output logic ack, output logic err, output int n);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_sel = sel; wb_adr = adr; wb_dat = dat;
    n = 0;
    while (n < 300) begin
      @(posedge clk); @(negedge clk);
      n++;
      if (wb_ack_o || wb_err_o) break;
      wb_we = 1'($urandom); wb_sel = 4'($urandom); wb_adr = $urandom; wb_dat = $urandom;
    end
    ack = wb_ack_o; err = wb_err_o; rd = wb_dat_o;
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("single_cycle_term", {31'h0, wb_ack_o | wb_err_o}, 32'h0);
  endtask

  task automatic mx(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                    input logic [31:0] dat, input string tag);
    logic e; logic [31:0] d; logic [31:0] rd; logic ack, err; int n;
    model_ref(we, sel, adr, dat, e, d);
    xfer(we, sel, adr, dat, rd, ack, err, n);
    chk({tag, "_latency"}, n, WC + 1);
    chk({tag, "_term"}, {30'h0, ack, err}, {30'h0, ~e, e});
    chk({tag, "_dat"}, rd, d);
  endtask

  initial begin
    vec_t tbl[12];
    logic [31:0] rd; logic ack, err; int n;
    logic e; logic [31:0] d;
    logic [31:0] oob_adr;
    logic [31:0] old3;
    bit seen;

    oob_adr = BASE + NW * 4 + 32'h10;
    tbl[0]  = '{1'b1, 4'hF, BASE + 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 4'h0, BASE + 32'h10, 32'h0,         1'b0, 32'hDEAD_BEEF};
    tbl[2]  = '{1'b1, 4'h5, BASE + 32'h10, 32'h1122_3344, 1'b0, 32'hDEAD_BEEF};
    tbl[3]  = '{1'b0, 4'hF, BASE + 32'h10, 32'h0,         1'b0, 32'hDE22_BE44};
    tbl[4]  = '{1'b1, 4'h0, BASE + 32'h10, 32'h5566_7788, 1'b0, 32'hDE22_BE44};
    tbl[5]  = '{1'b0, 4'h3, BASE + 32'h13, 32'h0,         1'b0, 32'hDE22_BE44};
    tbl[6]  = '{1'b1, 4'hF, BASE + 32'h14, 32'hCAFE_F00D, 1'b0, 32'hDE22_BE44};
    tbl[7]  = '{1'b1, 4'h8, BASE + 32'h14, 32'h00FF_00FF, 1'b0, 32'hDE22_BE44};
    tbl[8]  = '{1'b0, 4'h1, BASE + 32'h14, 32'h0,         1'b0, 32'h00FE_F00D};
`ifdef WB_RAM_ERR_EN
    tbl[9]  = '{1'b0, 4'hF, oob_adr,       32'h0,         1'b1, 32'h0};
    tbl[10] = '{1'b1, 4'hF, oob_adr,       32'hFFFF_FFFF, 1'b1, 32'h0};
    tbl[11] = '{1'b0, 4'hF, BASE + 32'h10, 32'h0,         1'b0, 32'hDE22_BE44};
`else
    tbl[9]  = '{1'b0, 4'hF, oob_adr,       32'h0,         1'b0, 32'hDE22_BE44};
    tbl[10] = '{1'b1, 4'hF, oob_adr,       32'hFFFF_FFFF, 1'b0, 32'hDE22_BE44};
    tbl[11] = '{1'b0, 4'hF, BASE + 32'h10, 32'h0,         1'b0, 32'hFFFF_FFFF};
`endif

    rstn_i = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    wb_sel = '0; wb_adr = '0; wb_dat = '0;
    last_rd = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset_ack", {31'h0, wb_ack_o}, 32'h0);
    chk("reset_err", {31'h0, wb_err_o}, 32'h0);
    chk("reset_dat", wb_dat_o, 32'h0);
    rstn_i = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 12; i++) begin
      xfer(tbl[i].we, tbl[i].sel, tbl[i].adr, tbl[i].dat, rd, ack, err, n);
      chk($sformatf("tbl%0d_latency", i), n, WC + 1);
      chk($sformatf("tbl%0d_term", i), {30'h0, ack, err}, {30'h0, ~tbl[i].exp_err, tbl[i].exp_err});
      chk($sformatf("tbl%0d_dat", i), rd, tbl[i].exp_dat);
    end
    last_rd = tbl[11].exp_dat;

    // Known contents for words 0..15
    for (int i = 0; i < 16; i++)
      mx(1'b1, 4'hF, BASE + 32'(i * 4), $urandom | 32'h1, "init");

    // Back-to-back reads with stb held: period WC+2, data in address order
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 4'($urandom); wb_adr = BASE;
    for (int k = 0; k < 8; k++) begin
      n = 0;
      do begin
        @(posedge clk); @(negedge clk);
        n++;
      end while (!wb_ack_o && n < 300);
      model_ref(1'b0, 4'hF, BASE + 32'(k * 4), 32'h0, e, d);
      chk($sformatf("b2b%0d_period", k), n, (k == 0) ? WC + 1 : WC + 2);
      chk($sformatf("b2b%0d_dat", k), wb_dat_o, d);
      if (k < 7) wb_adr = BASE + 32'((k + 1) * 4);
      else begin wb_cyc = 1'b0; wb_stb = 1'b0; end
    end
    seen = 1'b0;
    repeat (WC + 3) begin
      @(posedge clk); @(negedge clk);
      if (wb_ack_o || wb_err_o) seen = 1'b1;
    end
    chk("b2b_no_extra_ack", {31'h0, seen}, 32'h0);

    // Abort: cyc dropped in the first wait cycle, no termination, no write
    old3 = mdl[3];
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_sel = 4'hF;
    wb_adr = BASE + 32'hC; wb_dat = ~old3;
    @(posedge clk); @(negedge clk);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    seen = 1'b0;
    repeat (WC + 3) begin
      @(posedge clk); @(negedge clk);
      if (wb_ack_o || wb_err_o) seen = 1'b1;
    end
    chk("abort_no_ack", {31'h0, seen}, 32'h0);
    mx(1'b0, 4'hF, BASE + 32'hC, 32'h0, "abort_read");
    chk("abort_old_value", last_rd, old3);

    // Reset pulse mid-wait: outputs clear immediately, write discarded
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_sel = 4'hF;
    wb_adr = BASE + 32'h10; wb_dat = ~mdl[4];
    @(posedge clk); @(negedge clk);
    rstn_i = 1'b0;
    #1;
    chk("rst_mid_ack", {31'h0, wb_ack_o}, 32'h0);
    chk("rst_mid_err", {31'h0, wb_err_o}, 32'h0);
    chk("rst_mid_dat", wb_dat_o, 32'h0);
    last_rd = 32'h0;
    wb_cyc = 1'b0; wb_stb = 1'b0;
    #2 rstn_i = 1'b1;
    @(negedge clk);
    mx(1'b0, 4'hF, BASE + 32'h10, 32'h0, "rst_read");

    // Randomized traffic against the model
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 7) == 0) a = BASE + 32'((NW + $urandom_range(0, 15)) * 4);
      else a = BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      mx(1'($urandom), 4'($urandom), a, $urandom, "rand");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
